// File: rtl/in_debounce_pkg.sv
// Shared definitions for the in_debounce input-conditioning block.
//   state_t     : debounce FSM states
//   cnt_width() : width of the persistence counter, clog2(hold) with a floor of 1
//   *_DEF       : default parameter values for the block
package in_debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int HOLD_DEF        = 4;
  localparam int EVT_W_DEF       = 8;

  function automatic int cnt_width(input int hold);
    int w;
    w = $clog2(hold);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/in_debounce_if.sv
// Signal bundle between the debouncer and its user.
//   IN      : raw asynchronous level            (master -> slave)
//   EN      : debounce enable                   (master -> slave)
//   CLR     : synchronous clear of EVT_CNT      (master -> slave)
//   OUT     : debounced, registered level       (slave -> master)
//   RISE    : one-cycle pulse on OUT 0->1       (slave -> master)
//   FALL    : one-cycle pulse on OUT 1->0       (slave -> master)
//   BUSY    : candidate level change pending    (slave -> master)
//   EVT_CNT : saturating count of RISE events   (slave -> master)
interface in_debounce_if #(
  parameter int EVT_W = 8
);
  logic             IN;
  logic             EN;
  logic             CLR;
  logic             OUT;
  logic             RISE;
  logic             FALL;
  logic             BUSY;
  logic [EVT_W-1:0] EVT_CNT;

  modport master (
    output IN, EN, CLR,
    input  OUT, RISE, FALL, BUSY, EVT_CNT
  );

  modport slave (
    input  IN, EN, CLR,
    output OUT, RISE, FALL, BUSY, EVT_CNT
  );
endinterface

// File: rtl/in_debounce_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the CLK domain.
//   CLK : clock
//   RST : synchronous active-low reset, clears every stage
//   D   : asynchronous input
//   Q   : synchronised output (last stage)
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], D};
    end
  end

  assign Q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/in_debounce.sv
// Debounced input conditioner: synchronises IN, requires a new level to persist
// HOLD synchronised cycles before OUT follows, emits RISE/FALL pulses and
// counts rising events with saturation.
//   CLK : clock, all logic on posedge
//   RST : synchronous active-low reset
//   bus : in_debounce_if slave (IN, EN, CLR in; OUT, RISE, FALL, BUSY, EVT_CNT out)
module in_debounce
  import in_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int HOLD        = HOLD_DEF,
  parameter int EVT_W       = EVT_W_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  in_debounce_if.slave bus
);

  localparam int               CNT_W   = cnt_width(HOLD);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(HOLD - 1);
  localparam logic [EVT_W-1:0] SAT_MAX = {EVT_W{1'b1}};

  logic             w_sin;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_out,   w_out_nxt;
  logic             r_rise,  r_fall;
  logic [EVT_W-1:0] r_evt;
  logic             w_rise,  w_fall;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .D   (bus.IN),
    .Q   (w_sin)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    if (!bus.EN) begin
      // Disabled: drop any candidate so re-enabling starts a fresh count.
      w_state_nxt = STABLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        STABLE: begin
          if (w_sin == r_out) begin
            w_cnt_nxt = '0;
          end else if (HOLD == 1) begin
            w_out_nxt = ~r_out;
          end else begin
            w_state_nxt = PENDING;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        PENDING: begin
          if (w_sin == r_out) begin
            w_state_nxt = STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_END) begin
            w_out_nxt   = ~r_out;
            w_state_nxt = STABLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Pulse events are taken from the OUT transition itself, so the event
  // counter increments on the same edge the RISE register loads.
  assign w_rise = w_out_nxt & ~r_out;
  assign w_fall = ~w_out_nxt & r_out;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_evt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      if (bus.CLR && w_rise) begin
        r_evt <= EVT_W'(1);
      end else if (bus.CLR) begin
        r_evt <= '0;
      end else if (w_rise && (r_evt != SAT_MAX)) begin
        r_evt <= r_evt + 1'b1;
      end
    end
  end

  assign bus.OUT     = r_out;
  assign bus.RISE    = r_rise;
  assign bus.FALL    = r_fall;
  assign bus.BUSY    = (r_state == PENDING);
  assign bus.EVT_CNT = r_evt;

endmodule
